// File: rtl/mem_stage.sv
// mem_stage: Memory stage of the five-stage MIPS pipeline.
// Holds the E/M pipeline register and a word-addressed data memory.
// Stores commit on the rising clock edge. Loads are a combinational read.
// Store data can be taken from the Writeback result instead of the
// registered store data, so that a load followed by a store works.
// Optional feature: define MEM_TRACE_EN to print each committed store.
module mem_stage #(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic [1:0]  MemtoRegE,
  input  logic        MemWriteE,
  input  logic [31:0] ALUoutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
  input  logic [31:0] PC_4E,
  input  logic [31:0] ext_immE,
  input  logic [1:0]  TnewE,
  input  logic        forwardM,
  input  logic [31:0] ResultW,
  output logic        RegWriteM,
  output logic [1:0]  MemtoRegM,
  output logic [31:0] ALUoutM,
  output logic [31:0] ReadDataM,
  output logic [4:0]  WriteRegM,
  output logic [31:0] PC_4M,
  output logic [31:0] ext_immM,
  output logic [1:0]  TnewM
);

  // Tnew counts down toward 0 and holds there. It never wraps back to 3.
  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  logic        reg_write_p0;
  logic [1:0]  mem_to_reg_p0;
  logic        mem_write_p0;
  logic [31:0] alu_out_p0;
  logic [31:0] write_data_p0;
  logic [4:0]  write_reg_p0;
  logic [31:0] pc_4_p0;
  logic [31:0] ext_imm_p0;
  logic [1:0]  tnew_p0;

  logic [31:0]      dm [DM_WORDS];
  logic [DM_AW-1:0] idx;
  logic [31:0]      wdm;

  // ---- E -> M boundary ----
  // E/M register: loads every cycle because M never stalls. Reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_p0  <= 1'b0;
      mem_to_reg_p0 <= 2'd0;
      mem_write_p0  <= 1'b0;
      alu_out_p0    <= 32'd0;
      write_data_p0 <= 32'd0;
      write_reg_p0  <= 5'd0;
      pc_4_p0       <= 32'd0;
      ext_imm_p0    <= 32'd0;
      tnew_p0       <= 2'd0;
    end else begin
      reg_write_p0  <= RegWriteE;
      mem_to_reg_p0 <= MemtoRegE;
      mem_write_p0  <= MemWriteE;
      alu_out_p0    <= ALUoutE;
      write_data_p0 <= WriteDataE;
      write_reg_p0  <= WriteRegE;
      pc_4_p0       <= PC_4E;
      ext_imm_p0    <= ext_immE;
      tnew_p0       <= TnewE;
    end
  end

  // The word index drops the byte offset. Upper address bits are ignored, so addresses wrap.
  assign idx = alu_out_p0[DM_AW+1:2];
  // A late forward from Writeback covers a store that depends on the load just ahead of it.
  assign wdm = forwardM ? ResultW : write_data_p0;

  // ---- M stage: data memory ----
  // Data memory: reset clears every word. A store that is pending when reset arrives is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) dm[i] <= 32'd0;
    end else if (mem_write_p0) begin
      dm[idx] <= wdm;
    end
  end

`ifdef MEM_TRACE_EN
  logic [31:0] trace_addr;
  assign trace_addr = 32'({idx, 2'b00});

  // Store trace: prints the instruction PC, the word-aligned byte address and the data.
  always_ff @(posedge clk) begin
    if (!reset && mem_write_p0)
      $display("@%h: *%h <= %h", pc_4_p0 - 32'd4, trace_addr, wdm);
  end
`endif

  assign RegWriteM = reg_write_p0;
  assign MemtoRegM = mem_to_reg_p0;
  assign ALUoutM   = alu_out_p0;
  assign ReadDataM = dm[idx];
  assign WriteRegM = write_reg_p0;
  assign PC_4M     = pc_4_p0;
  assign ext_immM  = ext_imm_p0;
  assign TnewM     = sat_dec(tnew_p0);

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage. A behavioural model predicts the M outputs for every
// cycle. It pushes the prediction into a queue, and the prediction is popped
// and compared just after the clock edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemWriteE, forwardM;
  logic [1:0]  MemtoRegE, TnewE;
  logic [31:0] ALUoutE, WriteDataE, PC_4E, ext_immE, ResultW;
  logic [4:0]  WriteRegE;
  logic        RegWriteM;
  logic [1:0]  MemtoRegM, TnewM;
  logic [31:0] ALUoutM, ReadDataM, PC_4M, ext_immM;
  logic [4:0]  WriteRegM;

  mem_stage #(.DM_WORDS(1024), .DM_AW(10)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUoutE(ALUoutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .PC_4E(PC_4E), .ext_immE(ext_immE), .TnewE(TnewE),
    .forwardM(forwardM), .ResultW(ResultW),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .ALUoutM(ALUoutM),
    .ReadDataM(ReadDataM), .WriteRegM(WriteRegM), .PC_4M(PC_4M),
    .ext_immM(ext_immM), .TnewM(TnewM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  mtr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [1:0]  tnew;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Model state: the M register and the memory contents.
  logic        m_rw, m_mw;
  logic [1:0]  m_mtr, m_tnew;
  logic [31:0] m_alu, m_wd, m_pc, m_imm;
  logic [4:0]  m_wr;
  logic [31:0] model_mem [1024];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_rw = 0; m_mw = 0; m_mtr = 0; m_tnew = 0;
    m_alu = 0; m_wd = 0; m_pc = 0; m_imm = 0; m_wr = 0;
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".rw"},   32'(RegWriteM), 32'd0);
    check({tag, ".mtr"},  32'(MemtoRegM), 32'd0);
    check({tag, ".alu"},  ALUoutM, 32'd0);
    check({tag, ".rd"},   ReadDataM, 32'd0);
    check({tag, ".wr"},   32'(WriteRegM), 32'd0);
    check({tag, ".pc"},   PC_4M, 32'd0);
    check({tag, ".imm"},  ext_immM, 32'd0);
    check({tag, ".tnew"}, 32'(TnewM), 32'd0);
  endtask

  // Set the E-side inputs for the next instruction.
  task automatic drive(input logic mw, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] tn, input logic fwd, input logic [31:0] resw);
    RegWriteE  = ~mw;
    MemtoRegE  = mw ? 2'd0 : 2'd1;
    MemWriteE  = mw;
    ALUoutE    = addr;
    WriteDataE = wd;
    WriteRegE  = addr[6:2];
    PC_4E      = PC_4E + 32'd4;
    ext_immE   = {addr[15:0], wd[15:0]};
    TnewE      = tn;
    forwardM   = fwd;
    ResultW    = resw;
  endtask

  // Predict the results of one clock edge, run the edge, then compare.
  task automatic cycle(input string tag);
    exp_t e, got;
    if (m_mw) model_mem[m_alu[11:2]] = forwardM ? ResultW : m_wd;
    m_rw = RegWriteE; m_mtr = MemtoRegE; m_mw = MemWriteE; m_alu = ALUoutE;
    m_wd = WriteDataE; m_wr = WriteRegE; m_pc = PC_4E; m_imm = ext_immE;
    m_tnew = TnewE;
    e.rw = m_rw; e.mtr = m_mtr; e.alu = m_alu; e.wr = m_wr; e.pc = m_pc;
    e.imm = m_imm;
    e.tnew = (m_tnew == 2'd0) ? 2'd0 : m_tnew - 2'd1;
    e.rd = model_mem[m_alu[11:2]];
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    check({tag, ".rw"},   32'(RegWriteM), 32'(got.rw));
    check({tag, ".mtr"},  32'(MemtoRegM), 32'(got.mtr));
    check({tag, ".alu"},  ALUoutM, got.alu);
    check({tag, ".rd"},   ReadDataM, got.rd);
    check({tag, ".wr"},   32'(WriteRegM), 32'(got.wr));
    check({tag, ".pc"},   PC_4M, got.pc);
    check({tag, ".imm"},  ext_immM, got.imm);
    check({tag, ".tnew"}, 32'(TnewM), 32'(got.tnew));
  endtask

  initial begin
    reset = 1'b1;
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; ALUoutE = 0; WriteDataE = 0;
    WriteRegE = 0; PC_4E = 32'h0000_2ffc; ext_immE = 0; TnewE = 0;
    forwardM = 0; ResultW = 0;
    model_clear();
    #3;
    check_all_zero("por");
    @(posedge clk); #1;
    reset = 1'b0;

    // Store, then load from the same address. The store cycle still shows the old word.
    drive(1'b1, 32'h14, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0);
    cycle("sw14");
    check("tnew2", 32'(TnewM), 32'd1);
    drive(1'b0, 32'h14, 32'h0, 2'd0, 1'b0, 32'h0);
    cycle("lw14");
    check("lw14_data", ReadDataM, 32'hDEADBEEF);
    check("tnew0", 32'(TnewM), 32'd0);

    // Forwarded store: the register data is 0 and ResultW supplies the word.
    drive(1'b1, 32'h20, 32'h0, 2'd3, 1'b0, 32'h0);
    cycle("sw20");
    drive(1'b0, 32'h20, 32'h0, 2'd1, 1'b1, 32'h12345678);
    cycle("lw20");
    check("fwd_data", ReadDataM, 32'h12345678);

    // Wrap and alignment: 0x1003 maps to word 0.
    drive(1'b1, 32'h0000_1003, 32'hA5A5_0001, 2'd1, 1'b0, 32'hFFFF_FFFF);
    cycle("swwrap");
    drive(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 32'h0);
    cycle("lw0");
    check("wrap_data", ReadDataM, 32'hA5A5_0001);

    // Random traffic on a small address window.
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2 | 32'($urandom_range(0, 3)),
            $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      cycle("rand");
    end

    // Mid-cycle reset while a store sits in M. The store is dropped and memory clears.
    drive(1'b1, 32'h14, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0);
    cycle("sw_pre_rst");
    drive(1'b1, 32'h14, 32'h11111111, 2'd2, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_clear();
    @(posedge clk); #1;
    check_all_zero("rst_edge");
    reset = 1'b0;
    drive(1'b0, 32'h14, 32'h0, 2'd0, 1'b0, 32'h0);
    cycle("lw_after_rst");
    check("dm5_cleared", ReadDataM, 32'd0);
    drive(1'b0, 32'h20, 32'h0, 2'd0, 1'b0, 32'h0);
    cycle("lw20_after_rst");

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sbq_drain: %0d left, 0 expected", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
